// File: rtl/bus_ram.sv
// Memory-side responder for the CPU word bus: byte-lane banked RAM at BASE_ADDR with
// programmable wait states, fixed read latency and bus_error on out-of-window or dual requests.

module bus_ram_lane #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [7:0]            wr_byte,
  output logic [7:0]            rd_byte
);
  logic [7:0] mem [2**ADDR_WIDTH];

  // Contents survive reset; only the bus-side control state is cleared.
  always_ff @(posedge clk)
    if (we) mem[idx] <= wr_byte;

  assign rd_byte = mem[idx];
endmodule

module bus_ram #(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          READ_LATENCY = 2,
  parameter int          WAIT_STATES  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  input  logic        write_req,
  input  logic        read_req,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  output logic        bus_error
);
  localparam int STAGES  = READ_LATENCY - 1;
  localparam int NS      = STAGES + 1;
  localparam int TAG_LSB = ADDR_WIDTH + 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
    logic        rd;
  } req_t;

  req_t                  req;
  logic                  accept, in_win, dual, wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           ram_word, rd_word;
  logic [1:0]            wait_cnt;
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0][31:0] dat_pipe;
  logic                  unused_addr_bits;

  assign req = '{addr: addr, data: write_data, be: byte_enable, wr: write_req, rd: read_req};
  assign unused_addr_bits = ^req.addr[1:0];

  assign ready  = (wait_cnt == 2'd0);
  assign accept = ready & (req.rd | req.wr);
  assign in_win = (req.addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign idx    = req.addr[TAG_LSB-1:2];
  assign dual   = req.rd & req.wr;
  // A dual request degrades to a write, so a read only proceeds with write_req low.
  assign wr_acc = accept & req.wr & in_win;
  assign rd_acc = accept & req.rd & ~req.wr;
  assign rd_word = in_win ? ram_word : '0;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    bus_ram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk     (clk),
      .we      (wr_acc & req.be[i]),
      .idx     (idx),
      .wr_byte (req.data[8*i +: 8]),
      .rd_byte (ram_word[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)               wait_cnt <= '0;
    else if (accept)            wait_cnt <= 2'(WAIT_STATES);
    else if (wait_cnt != 2'd0)  wait_cnt <= wait_cnt - 2'd1;

  // Each stage only loads when a valid beat enters it, so the last stage holds
  // the previous return data between beats.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | NS'(rd_acc);
      if (rd_acc) dat_pipe[0] <= rd_word;
      for (int s = 1; s <= STAGES; s++)
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bus_error <= 1'b0;
    else          bus_error <= accept & (~in_win | dual);

  assign read_data_valid = vld_pipe[STAGES];
  assign read_data       = dat_pipe[STAGES];
endmodule
